seq_shifter: RTL and testbench

- Multi-cycle, iterative counterpart to the single-cycle combinational barrel shifter.
- Performs the same shift operations (same operand, shift amount and direction semantics) by shifting one bit position per clock.
- Uses a start/busy/done handshake.
- Used in the datapath where area matters more than latency, and as a cycle-accurate golden model alongside the combinational unit.

---
 rtl/seq_shifter_pkg.sv | 18 +
 rtl/seq_shifter_if.sv | 24 ++
 rtl/seq_shifter_shift_step.sv | 37 +++
 rtl/seq_shifter.sv | 94 +++++++++
 tb/tb_seq_shifter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the iterative shifter: shift modes, direction and FSM states.
// The direction encoding matches the combinational barrel shifter.
package seq_shifter_pkg;

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ARI  = 2'b01;
  localparam logic [1:0] MODE_ROT  = 2'b10;

  localparam logic       DIR_RIGHT = 1'b0;
  localparam logic       DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle of the iterative shifter; the slave side is the shifter itself.
interface seq_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, in, shamt, dir, mode,
    input  busy, done, out
  );

  modport slave (
    input  start, in, shamt, dir, mode,
    output busy, done, out
  );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// One-bit shift step: applies a single logical/arithmetic/rotate shift to a value.
// Reserved mode 2'b11 falls through to logical.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  logic fill_s;

  // Select the bit shifted in and assemble the shifted word.
  always_comb begin
    fill_s = 1'b0;
    result = value;
    if (dir == DIR_LEFT) begin
      if (mode == MODE_ROT) begin
        fill_s = value[WIDTH-1];
      end else begin
        fill_s = 1'b0;
      end
      result = {value[WIDTH-2:0], fill_s};
    end else begin
      case (mode)
        MODE_ARI: fill_s = value[WIDTH-1];
        MODE_ROT: fill_s = value[0];
        default:  fill_s = 1'b0;
      endcase
      result = {fill_s, value[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shifter: one bit position per clock with a start/busy/done handshake.
// Holds the FSM, the remaining-step counter and the result register.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] out_r, out_nxt_s, step_s;
  logic [SHW-1:0]   cnt_r, cnt_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic [1:0]       mode_r, mode_nxt_s;
  logic             busy_r, done_r;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (out_r),
    .dir    (dir_r),
    .mode   (mode_r),
    .result (step_s)
  );

  // Next-state, counter and datapath update; a start is only seen when not shifting.
  always_comb begin
    state_nxt_s = state_r;
    out_nxt_s   = out_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          out_nxt_s  = bus.in;
          cnt_nxt_s  = bus.shamt;
          dir_nxt_s  = bus.dir;
          mode_nxt_s = bus.mode;
          if (bus.shamt == CNT_ZERO) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_SHIFT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        out_nxt_s = step_s;
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      out_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
      mode_r  <= mode_nxt_s;
      busy_r  <= (state_nxt_s == S_SHIFT);
      done_r  <= (state_nxt_s == S_DONE);
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter with hand-computed expected results.
module tb_seq_shifter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_shifter_if #(.WIDTH(8), .SHW(3)) bus ();

  seq_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs afterwards and wait for done (bounded).
  task automatic run_op(input logic [7:0] a, input logic [2:0] s, input logic d,
                        input logic [1:0] m, input logic [7:0] exp, input string tag);
    int lat;
    int nbusy;
    int both;
    bus.in    = a;
    bus.shamt = s;
    bus.dir   = d;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in    = ~a;
    bus.shamt = ~s;
    bus.dir   = ~d;
    bus.mode  = ~m;
    lat   = 0;
    nbusy = 0;
    both  = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
    if (bus.busy === 1'b1 && bus.done === 1'b1) both = 1;
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_lat"}, lat, {29'd0, s});
    check({tag, "_busycnt"}, nbusy, {29'd0, s});
    check({tag, "_busydone"}, both, 32'd0);
    check({tag, "_out"}, {24'd0, bus.out}, {24'd0, exp});
  endtask

  initial begin
    int lat;
    int seen;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = 8'h00;
    bus.shamt = 3'd0;
    bus.dir   = 1'b0;
    bus.mode  = 2'b00;
    tick();
    tick();
    check("rst_out", {24'd0, bus.out}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(8'b10011010, 3'd5, 1'b0, 2'b00, 8'b00000100, "t1_rlog5");
    tick();
    run_op(8'b10010011, 3'd7, 1'b1, 2'b00, 8'b10000000, "t2_llog7");
    tick();
    run_op(8'b10010011, 3'd3, 1'b1, 2'b10, 8'b10011100, "t2_lrot3");
    tick();
    run_op(8'b10011010, 3'd3, 1'b0, 2'b01, 8'b11110011, "t3_rari3");
    tick();
    run_op(8'b10011010, 3'd5, 1'b0, 2'b10, 8'b11010100, "t3_rrot5");
    tick();
    run_op(8'hF0, 3'd2, 1'b0, 2'b11, 8'h3C, "rsv_rlog2");
    tick();
    run_op(8'h81, 3'd1, 1'b1, 2'b01, 8'h02, "lari1");
    tick();
    run_op(8'h01, 3'd1, 1'b0, 2'b10, 8'h80, "rrot1");
    tick();

    // shamt=0 then back-to-back start issued in the DONE cycle
    run_op(8'hA5, 3'd0, 1'b1, 2'b10, 8'hA5, "t4_zero");
    run_op(8'h0F, 3'd1, 1'b1, 2'b00, 8'h1E, "t4_b2b");
    tick();

    // start during SHIFT is ignored
    bus.in    = 8'hFF;
    bus.shamt = 3'd6;
    bus.dir   = 1'b0;
    bus.mode  = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.in    = 8'h00;
    bus.shamt = 3'd1;
    bus.dir   = 1'b1;
    bus.mode  = 2'b10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_busy", {31'd0, bus.busy}, 32'd1);
    lat = 2;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("t5_lat", lat, 32'd6);
    check("t5_out", {24'd0, bus.out}, 32'h03);
    tick();

    // reset mid-operation abandons it
    bus.in    = 8'hFF;
    bus.shamt = 3'd7;
    bus.dir   = 1'b1;
    bus.mode  = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out", {24'd0, bus.out}, 32'd0);
    check("t6_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_done", {31'd0, bus.done}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    check("t6_quiet", seen, 32'd0);
    run_op(8'hC3, 3'd2, 1'b0, 2'b01, 8'hF0, "t6_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
